// File: rtl/iexecute_pkg.sv
// Shared definitions for the EX stage: ALU control codes, aluop
// encodings, R-type funct values and control-bundle bit positions.
package iexecute_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluCodeE;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluOpE;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

endpackage

// File: rtl/iexecute_alu_control.sv
// ALU control decoder: turns the two-bit aluop from decode plus the
// R-type funct field into the three-bit operation code the ALU uses.
module alu_control
  import iexecute_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output aluCodeE    o_aluCtl
);

  // Loads/stores and the reserved encoding add; branches subtract;
  // only R-type looks at funct, and unknown functs fall back to add.
  always_comb begin
    o_aluCtl = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD:  o_aluCtl = ALU_ADD;
      ALUOP_SUB:  o_aluCtl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_aluCtl = ALU_ADD;
          FUNCT_SUB: o_aluCtl = ALU_SUB;
          FUNCT_AND: o_aluCtl = ALU_AND;
          FUNCT_OR:  o_aluCtl = ALU_OR;
          FUNCT_SLT: o_aluCtl = ALU_SLT;
          default:   o_aluCtl = ALU_ADD;
        endcase
      end
      default:    o_aluCtl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/iexecute.sv
// EX stage of the 5-stage MIPS pipeline: branch-target adder, ALU,
// destination-register mux and the EX/MEM pipeline latch. The latched
// branch decision is fed back to fetch.
module iexecute
  import iexecute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_AW-1:0] instr_2016,
  input  logic [REG_AW-1:0] instr_1511,
  output logic [1:0]        wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic [DATA_W-1:0] add_result,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_AW-1:0] dest_reg,
  output logic              EX_MEM_PCSrc,
  output logic [DATA_W-1:0] EX_MEM_NPC
);

  aluCodeE           w_aluCtl;
  logic [DATA_W-1:0] w_aluB;
  logic [DATA_W-1:0] w_aluResult;
  logic [DATA_W-1:0] w_branchTarget;
  logic [REG_AW-1:0] w_destReg;

  logic [1:0]        r_wbCtl;
  logic              r_branch;
  logic              r_memRead;
  logic              r_memWrite;
  logic [DATA_W-1:0] r_addResult;
  logic              r_zero;
  logic [DATA_W-1:0] r_aluResult;
  logic [DATA_W-1:0] r_rdata2;
  logic [REG_AW-1:0] r_destReg;

  alu_control uAluControl (
    .i_aluop  (aluop),
    .i_funct  (s_extend[5:0]),
    .o_aluCtl (w_aluCtl)
  );

  // Operand select, branch target, and destination register select.
  always_comb begin
    w_aluB         = alusrc ? s_extend : rdata2;
    w_branchTarget = npc + {s_extend[DATA_W-3:0], 2'b00};
    w_destReg      = regdst ? instr_1511 : instr_2016;
  end

  // ALU proper; add/sub wrap silently, slt is signed, undefined codes give 0.
  always_comb begin
    w_aluResult = '0;
    case (w_aluCtl)
      ALU_AND: w_aluResult = rdata1 & w_aluB;
      ALU_OR:  w_aluResult = rdata1 | w_aluB;
      ALU_ADD: w_aluResult = rdata1 + w_aluB;
      ALU_SUB: w_aluResult = rdata1 - w_aluB;
      ALU_SLT: w_aluResult = {{(DATA_W-1){1'b0}},
                              ($signed(rdata1) < $signed(w_aluB))};
      default: w_aluResult = '0;
    endcase
  end

  // EX/MEM latch: cleared whole on reset, otherwise loaded every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbCtl     <= '0;
      r_branch    <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_addResult <= '0;
      r_zero      <= 1'b0;
      r_aluResult <= '0;
      r_rdata2    <= '0;
      r_destReg   <= '0;
    end else begin
      r_wbCtl     <= wb_ctl;
      r_branch    <= m_ctl[M_BRANCH];
      r_memRead   <= m_ctl[M_MEMREAD];
      r_memWrite  <= m_ctl[M_MEMWRITE];
      r_addResult <= w_branchTarget;
      r_zero      <= (w_aluResult == '0);
      r_aluResult <= w_aluResult;
      r_rdata2    <= rdata2;
      r_destReg   <= w_destReg;
    end
  end

  // Outputs come straight from the latch, so the fetch feedback never
  // depends on the instruction currently sitting in EX.
  always_comb begin
    wb_ctlout    = r_wbCtl;
    branch       = r_branch;
    memread      = r_memRead;
    memwrite     = r_memWrite;
    add_result   = r_addResult;
    zero         = r_zero;
    alu_result   = r_aluResult;
    rdata2out    = r_rdata2;
    dest_reg     = r_destReg;
    EX_MEM_PCSrc = r_branch & r_zero;
    EX_MEM_NPC   = r_addResult;
  end

endmodule

// File: tb/tb_iexecute.sv
// Scoreboard testbench for the EX stage: a driver issues directed and
// random instructions and queues the expected EX/MEM contents; a monitor
// pops and compares one entry after every rising edge.
module tb_iexecute;

  typedef struct {
    bit              doReset;
    logic [1:0]      wb;
    logic [2:0]      m;
    logic            regdst;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [31:0]     npc;
    logic [31:0]     r1;
    logic [31:0]     r2;
    logic [31:0]     sext;
    logic [4:0]      rt;
    logic [4:0]      rd;
  } stimT;

  typedef struct {
    logic [1:0]  wb;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] addRes;
    logic        zero;
    logic [31:0] aluRes;
    logic [31:0] rd2;
    logic [4:0]  dest;
    logic        pcsrc;
    logic [31:0] npcOut;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  wb_ctl = '0;
  logic [2:0]  m_ctl = '0;
  logic        regdst = 1'b0;
  logic        alusrc = 1'b0;
  logic [1:0]  aluop = '0;
  logic [31:0] npc = '0;
  logic [31:0] rdata1 = '0;
  logic [31:0] rdata2 = '0;
  logic [31:0] s_extend = '0;
  logic [4:0]  instr_2016 = '0;
  logic [4:0]  instr_1511 = '0;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero, EX_MEM_PCSrc;
  logic [31:0] add_result, alu_result, rdata2out, EX_MEM_NPC;
  logic [4:0]  dest_reg;

  expT expQ[$];
  int  testCount = 0;
  int  failCount = 0;
  bit  driverDone = 1'b0;

  iexecute #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst),
    .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1),
    .rdata2(rdata2), .s_extend(s_extend), .instr_2016(instr_2016),
    .instr_1511(instr_1511), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .dest_reg(dest_reg), .EX_MEM_PCSrc(EX_MEM_PCSrc), .EX_MEM_NPC(EX_MEM_NPC)
  );

  always #5 clk = ~clk;

  // Reference model: MIPS EX semantics written as plain arithmetic on the
  // instruction's meaning rather than on any control encoding.
  function automatic expT model(input stimT s);
    expT e;
    longint unsigned b, a, res;
    string op;
    e = '{default: '0};
    if (s.doReset) return e;
    a = s.r1;
    b = s.alusrc ? s.sext : s.r2;
    op = "add";
    if (s.aluop == 2'd1) op = "sub";
    else if (s.aluop == 2'd2) begin
      case (int'(s.sext[5:0]))
        32: op = "add";
        34: op = "sub";
        36: op = "and";
        37: op = "or";
        42: op = "slt";
        default: op = "add";
      endcase
    end
    if (op == "add") res = (a + b) % 64'h1_0000_0000;
    else if (op == "sub") res = (a + 64'h1_0000_0000 - b) % 64'h1_0000_0000;
    else if (op == "and") res = a & b;
    else if (op == "or") res = a | b;
    else res = (int'(s.r1) < int'(b[31:0])) ? 1 : 0;
    e.wb       = s.wb;
    e.branch   = s.m[2];
    e.memread  = s.m[1];
    e.memwrite = s.m[0];
    e.addRes   = 32'((longint'(s.npc) + longint'(s.sext) * 4) % 64'h1_0000_0000);
    e.aluRes   = res[31:0];
    e.zero     = (res == 0);
    e.rd2      = s.r2;
    e.dest     = s.regdst ? s.rd : s.rt;
    e.pcsrc    = e.branch && e.zero;
    e.npcOut   = e.addRes;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue its expected result.
  task automatic applyStimulus(input stimT s);
    @(negedge clk);
    rst        = s.doReset;
    wb_ctl     = s.wb;
    m_ctl      = s.m;
    regdst     = s.regdst;
    alusrc     = s.alusrc;
    aluop      = s.aluop;
    npc        = s.npc;
    rdata1     = s.r1;
    rdata2     = s.r2;
    s_extend   = s.sext;
    instr_2016 = s.rt;
    instr_1511 = s.rd;
    expQ.push_back(model(s));
  endtask

  task automatic checkOutput(input expT e);
    cmp("wb_ctlout", 32'(wb_ctlout), 32'(e.wb));
    cmp("branch", 32'(branch), 32'(e.branch));
    cmp("memread", 32'(memread), 32'(e.memread));
    cmp("memwrite", 32'(memwrite), 32'(e.memwrite));
    cmp("add_result", add_result, e.addRes);
    cmp("zero", 32'(zero), 32'(e.zero));
    cmp("alu_result", alu_result, e.aluRes);
    cmp("rdata2out", rdata2out, e.rd2);
    cmp("dest_reg", 32'(dest_reg), 32'(e.dest));
    cmp("EX_MEM_PCSrc", 32'(EX_MEM_PCSrc), 32'(e.pcsrc));
    cmp("EX_MEM_NPC", EX_MEM_NPC, e.npcOut);
  endtask

  // Monitor: one latch update per rising edge, so one scoreboard entry each.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  function automatic stimT mk(input bit rs, input logic [1:0] wb, input logic [2:0] m,
                              input logic rdst, input logic asrc, input logic [1:0] aop,
                              input logic [31:0] pc, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] se,
                              input logic [4:0] rt, input logic [4:0] rd);
    stimT s;
    s.doReset = rs; s.wb = wb; s.m = m; s.regdst = rdst; s.alusrc = asrc;
    s.aluop = aop; s.npc = pc; s.r1 = a; s.r2 = b; s.sext = se;
    s.rt = rt; s.rd = rd;
    return s;
  endfunction

  function automatic stimT randStim();
    stimT s;
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    s.doReset = ($urandom_range(0, 19) == 0);
    s.wb      = 2'($urandom);
    s.m       = 3'($urandom);
    s.regdst  = 1'($urandom);
    s.alusrc  = 1'($urandom);
    s.aluop   = 2'($urandom);
    s.npc     = $urandom;
    s.r1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    s.r2      = ($urandom_range(0, 2) == 0) ? s.r1 : $urandom;
    s.sext    = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      s.sext[5:0] = functs[$urandom_range(0, 4)];
    end
    if ($urandom_range(0, 7) == 0) s.sext = {26'h0, functs[5]};
    s.rt      = 5'($urandom);
    s.rd      = 5'($urandom);
    return s;
  endfunction

  initial begin
    // reset held two cycles with busy inputs
    applyStimulus(mk(1, 2'b11, 3'b111, 1, 1, 2'b10, 32'h1234, 32'h55, 32'h66, 32'h20, 5'd9, 5'd10));
    applyStimulus(mk(1, 2'b11, 3'b111, 1, 1, 2'b10, 32'h1234, 32'h55, 32'h66, 32'h20, 5'd9, 5'd10));
    // R-type add
    applyStimulus(mk(0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3));
    // slt signed and swapped
    applyStimulus(mk(0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd2, 5'd4));
    applyStimulus(mk(0, 2'b10, 3'b000, 1, 0, 2'b10, 32'hC, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd2, 5'd4));
    // beq taken, then not taken
    applyStimulus(mk(0, 2'b00, 3'b100, 0, 0, 2'b01, 32'h100, 32'd9, 32'd9, 32'd4, 5'd1, 5'd1));
    applyStimulus(mk(0, 2'b00, 3'b100, 0, 0, 2'b01, 32'h100, 32'd9, 32'd8, 32'd4, 5'd1, 5'd1));
    // lw with negative offset
    applyStimulus(mk(0, 2'b11, 3'b010, 0, 1, 2'b00, 32'h40, 32'h1000, 32'h0, 32'hFFFFFFFC, 5'd8, 5'd12));
    // branch-target wrap-around and reserved aluop
    applyStimulus(mk(0, 2'b00, 3'b000, 0, 1, 2'b11, 32'hFFFFFFF0, 32'h7FFFFFFF, 32'h3, 32'h00000008, 5'd5, 5'd6));
    // beq taken then reset on the very next edge
    applyStimulus(mk(0, 2'b00, 3'b100, 0, 0, 2'b01, 32'h200, 32'd3, 32'd3, 32'd1, 5'd1, 5'd1));
    applyStimulus(mk(1, 2'b00, 3'b100, 0, 0, 2'b01, 32'h200, 32'd3, 32'd3, 32'd1, 5'd1, 5'd1));
    // bubble
    applyStimulus(mk(0, 2'b00, 3'b000, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0));
    // back-to-back random traffic
    for (int i = 0; i < 300; i++) applyStimulus(randStim());
    @(negedge clk);
    rst = 1'b0;
    m_ctl = '0;
    wb_ctl = '0;
    driverDone = 1'b1;
  end

  // End of run: give the monitor a bounded window to drain the scoreboard.
  initial begin
    wait (driverDone);
    for (int c = 0; c < 10 && expQ.size() > 0; c++) @(negedge clk);
    cmp("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Hard time limit so the run always ends even if the driver stalls.
  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/iexecute.md
Name: iexecute

Overview:
- EX stage of the 5-stage MIPS pipeline; consumes the ID/EX latch outputs produced by the decode stage.
- Computes the branch target, ALU control, ALU result/zero, and destination register select.
- Registers the results into the EX/MEM latch.
- Drives EX_MEM_PCSrc/EX_MEM_NPC back to instruction fetch, closing the branch loop.

Parameters:
- DATA_W, 32, datapath width (instruction, PC, operands).
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_ctl  input  2  ID/EX WB control: [1]=regwrite, [0]=memtoreg.
- m_ctl  input  3  ID/EX MEM control: [2]=branch, [1]=memread, [0]=memwrite.
- regdst  input  1  1: dest=instr_1511, 0: dest=instr_2016.
- alusrc  input  1  1: ALU B=s_extend, 0: ALU B=rdata2.
- aluop  input  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved.
- npc  input  DATA_W  PC+4 of instruction in EX.
- rdata1  input  DATA_W  register operand A.
- rdata2  input  DATA_W  register operand B / store data.
- s_extend  input  DATA_W  sign-extended immediate; [5:0] is funct.
- instr_2016  input  REG_AW  rt field.
- instr_1511  input  REG_AW  rd field.
- wb_ctlout  output  2  latched wb_ctl.
- branch, memread, memwrite  output  1 each  latched m_ctl bits.
- add_result  output  DATA_W  latched branch target.
- zero  output  1  latched ALU-result==0.
- alu_result  output  DATA_W  latched ALU result.
- rdata2out  output  DATA_W  latched rdata2 (store data).
- dest_reg  output  REG_AW  latched destination register.
- EX_MEM_PCSrc  output  1  branch & zero, combinational from latched values.
- EX_MEM_NPC  output  DATA_W  equals add_result.

Behaviour:
- Reset: if rst is high at a rising edge, every latched output is cleared to 0. Consequently EX_MEM_PCSrc=0 and EX_MEM_NPC=0. Reset overrides any in-flight instruction; nothing is partially latched.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. No stall or handshake; the latch updates every non-reset cycle.
- Branch adder: add_result = npc + (s_extend << 2), modulo 2^DATA_W. Wrap-around is silent.
- ALU control, 3-bit code:
  - aluop=00 -> 010 (add).
  - aluop=01 -> 110 (sub).
  - aluop=10 decodes funct: 100000->010 add, 100010->110 sub, 100100->000 and, 100101->001 or, 101010->111 slt. Any other funct -> 010.
  - aluop=11 -> 010.
- ALU: operates on A=rdata1 and B=mux(alusrc).
  - add/sub wrap modulo 2^DATA_W; there is no overflow trap.
  - slt is a signed compare; result is 1 or 0, zero-extended.
  - Unused codes produce 0.
  - zero = (ALU result == 0), evaluated on the same value that is latched.
- Dest mux: dest_reg = regdst ? instr_1511 : instr_2016.
- Pass-through: rdata2 (unmuxed) -> rdata2out; wb_ctl and m_ctl bits are latched unchanged.
- PCSrc: EX_MEM_PCSrc = branch & zero, taken from the latched registers only; it never combinationally depends on current inputs.
- Bubble: all-zero control inputs produce no side effects downstream (regwrite=0, memwrite=0, branch=0).

Decomposition:
- Shared package holds:
  - ALU control codes: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - aluop encodings.
  - funct constants.
  - m_ctl/wb_ctl bit indices.
- One natural sub-module, alu_control: aluop and funct in, 3-bit ALU code out; purely combinational.
- The ALU, adder, muxes and EX/MEM latch stay in iexecute.

Test Plan:
- rst=1 for 2 cycles with nonzero inputs -> all outputs 0; EX_MEM_PCSrc=0.
- R-type add: aluop=10, funct=100000, rdata1=5, rdata2=7, alusrc=0, regdst=1, rd=3 -> next cycle alu_result=12, zero=0, dest_reg=3.
- slt signed: rdata1=0xFFFFFFFF, rdata2=1, funct=101010 -> alu_result=1. Swap operands -> alu_result=0, zero=1.
- beq taken:
  - Stimulus: m_ctl=100, aluop=01, rdata1=rdata2=9, npc=0x100, s_extend=4.
  - Required: add_result=0x110, zero=1, EX_MEM_PCSrc=1, EX_MEM_NPC=0x110.
  - With rdata2=8 instead: EX_MEM_PCSrc=0.
- lw: aluop=00, alusrc=1, rdata1=0x1000, s_extend=0xFFFFFFFC, regdst=0, rt=8, wb_ctl=11, m_ctl=010 -> alu_result=0xFFC, dest_reg=8, memread=1, wb_ctlout=11.
- Reset mid-stream: beq taken latched, then rst=1 next edge -> EX_MEM_PCSrc drops to 0 after that edge. Back-to-back instructions on consecutive cycles each appear exactly one cycle later.
